// File: rtl/zjh_counter_n.sv
// zjh_counter_n: parametrised modulo-N up/down counter with 74HC161-style
// Cep/Cet/TC cascading, synchronous clear, clamped load, optional one-shot
// saturation and a registered one-cycle wrap pulse.
//
// Ports:
//   Clk   in          rising-edge clock
//   MR    in          asynchronous reset, active-high
//   SR    in          synchronous clear, active-high (highest priority)
//   Ld    in          synchronous load of D, clamped to MODULUS-1
//   Cep   in          parallel count enable
//   Cet   in          trickle count enable, also gates TC
//   Dir   in          1 = count up, 0 = count down
//   D     in  WIDTH   load value
//   Q     out WIDTH   current count, always within 0..MODULUS-1
//   TC    out         combinational terminal count, Cet & (Q == terminal)
//   Ovf   out         registered pulse in the cycle after a wrap
//   Done  out         sticky flag set when a saturating counter hits terminal
module zjh_counter_n #(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = 256,
    parameter bit     WRAP    = 1'b1
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic             SR,
    input  logic             Ld,
    input  logic             Cep,
    input  logic             Cet,
    input  logic             Dir,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Ovf,
    output logic             Done
);

    // One extra bit so that MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_EXT = MOD_EXT - (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAXV    = MAX_EXT[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             r_done;

    logic [WIDTH-1:0] w_tv;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_wrap_val;
    logic [WIDTH-1:0] w_clamp;
    logic             w_at_tv;
    logic             w_count;
    logic             w_in_range;

    assign w_tv       = Dir ? MAXV : '0;
    assign w_at_tv    = (r_q == w_tv);
    assign w_count    = Cep & Cet;

    // Only used when Q is not at the terminal value, so the step never
    // overflows or underflows the 0..MODULUS-1 range.
    assign w_step     = Dir ? (r_q + 1'b1) : (r_q - 1'b1);

    // Wrap is an explicit compare-and-reload, not a natural overflow.
    assign w_wrap_val = Dir ? '0 : MAXV;

    assign w_in_range = ({1'b0, D} < MOD_EXT);
    assign w_clamp    = w_in_range ? D : MAXV;

    always_ff @(posedge Clk or posedge MR) begin
        if (MR) begin
            r_q    <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            // Ovf is a single-cycle pulse; only a wrap re-asserts it.
            r_ovf <= 1'b0;
            if (SR) begin
                r_q    <= '0;
                r_done <= 1'b0;
            end else if (Ld) begin
                r_q    <= w_clamp;
                r_done <= 1'b0;
            end else if (w_count) begin
                if (!w_at_tv) begin
                    r_q <= w_step;
                end else if (WRAP) begin
                    r_q   <= w_wrap_val;
                    r_ovf <= 1'b1;
                end else begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign Q    = r_q;
    assign Ovf  = r_ovf;
    assign Done = r_done;
    assign TC   = Cet & w_at_tv;

endmodule

// File: tb/tb_zjh_counter_n.sv
// Bench for zjh_counter_n: vector table, hand-written corner sequences,
// two-stage decimal cascade and randomized run against a reference model.
module tb_zjh_counter_n;

    logic Clk;
    logic MR;

    logic       a_sr, a_ld, a_cep, a_cet, a_dir;
    logic [3:0] a_d;
    logic [3:0] a_q;
    logic       a_tc, a_ovf, a_done;

    logic [2:0] b_q;
    logic       b_tc, b_ovf, b_done;

    logic       s_sr, s_ld, s_cep, s_cet, s_dir;
    logic [3:0] s_d;
    logic [3:0] s_q;
    logic       s_tc, s_ovf, s_done;

    logic       c_cep, c_dir;
    logic [3:0] c0_q, c1_q;
    logic       c0_tc, c0_ovf, c0_done;
    logic       c1_tc, c1_ovf, c1_done;

    int n_chk  = 0;
    int n_fail = 0;

    zjh_counter_n #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_a (
        .Clk(Clk), .MR(MR), .SR(a_sr), .Ld(a_ld), .Cep(a_cep),
        .Cet(a_cet), .Dir(a_dir), .D(a_d),
        .Q(a_q), .TC(a_tc), .Ovf(a_ovf), .Done(a_done)
    );

    zjh_counter_n #(.WIDTH(3), .MODULUS(2), .WRAP(1'b1)) u_b (
        .Clk(Clk), .MR(MR), .SR(a_sr), .Ld(a_ld), .Cep(a_cep),
        .Cet(a_cet), .Dir(a_dir), .D(a_d[2:0]),
        .Q(b_q), .TC(b_tc), .Ovf(b_ovf), .Done(b_done)
    );

    zjh_counter_n #(.WIDTH(4), .MODULUS(6), .WRAP(1'b0)) u_s (
        .Clk(Clk), .MR(MR), .SR(s_sr), .Ld(s_ld), .Cep(s_cep),
        .Cet(s_cet), .Dir(s_dir), .D(s_d),
        .Q(s_q), .TC(s_tc), .Ovf(s_ovf), .Done(s_done)
    );

    zjh_counter_n #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_c0 (
        .Clk(Clk), .MR(MR), .SR(1'b0), .Ld(1'b0), .Cep(c_cep),
        .Cet(1'b1), .Dir(c_dir), .D(4'd0),
        .Q(c0_q), .TC(c0_tc), .Ovf(c0_ovf), .Done(c0_done)
    );

    zjh_counter_n #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_c1 (
        .Clk(Clk), .MR(MR), .SR(1'b0), .Ld(1'b0), .Cep(c_cep),
        .Cet(c0_tc), .Dir(c_dir), .D(4'd0),
        .Q(c1_q), .TC(c1_tc), .Ovf(c1_ovf), .Done(c1_done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: state kept as plain integers, modulo arithmetic.
    typedef struct {
        int q;
        bit ovf;
        bit done;
    } st_t;

    function automatic st_t mstep(st_t s, bit sr, bit ld, bit cep, bit cet,
                                  bit dir, int d, int m, bit wrap);
        st_t n;
        int  tv;
        n     = s;
        n.ovf = 1'b0;
        tv    = dir ? m - 1 : 0;
        if (sr) begin
            n.q    = 0;
            n.done = 1'b0;
        end else if (ld) begin
            n.q    = (d < m) ? d : m - 1;
            n.done = 1'b0;
        end else if (cep && cet) begin
            if (s.q != tv) begin
                n.q = (s.q + (dir ? 1 : m - 1)) % m;
            end else if (wrap) begin
                n.q   = (s.q + (dir ? 1 : m - 1)) % m;
                n.ovf = 1'b1;
            end else begin
                n.done = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic bit mtc(int q, bit cet, bit dir, int m);
        return cet && (q == (dir ? m - 1 : 0));
    endfunction

    typedef struct {
        logic       sr, ld, cep, cet, dir;
        logic [3:0] d;
        int         q;
        logic       ovf, tc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic sr, logic ld, logic cep, logic cet,
                                logic dir, logic [3:0] d, int q,
                                logic ovf, logic tc);
        vec_t v;
        v = '{sr, ld, cep, cet, dir, d, q, ovf, tc};
        return v;
    endfunction

    task automatic edge1();
        @(posedge Clk);
        #1;
    endtask

    st_t ma, mb, ms;

    initial begin
        a_sr = 0; a_ld = 0; a_cep = 1; a_cet = 1; a_dir = 0; a_d = 0;
        s_sr = 0; s_ld = 0; s_cep = 0; s_cet = 1; s_dir = 1; s_d = 0;
        c_cep = 0; c_dir = 1;
        MR = 1'b0;
        #1;
        MR = 1'b1;
        #11;
        // Reset state, t = 12
        chk("rst_a_q", a_q, 0);
        chk("rst_a_ovf", a_ovf, 0);
        chk("rst_a_done", a_done, 0);
        chk("rst_a_tc_down", a_tc, 1);
        chk("rst_b_tc_down", b_tc, 1);
        chk("rst_s_q", s_q, 0);
        chk("rst_s_done", s_done, 0);
        chk("rst_s_tc_up", s_tc, 0);
        chk("rst_c_q", int'(c1_q) * 10 + int'(c0_q), 0);
        chk("rst_c_ovf", c0_ovf | c1_ovf, 0);
        chk("rst_c_done", c0_done | c1_done, 0);
        a_dir = 1'b1;
        #1;
        chk("rst_a_tc_up", a_tc, 0);
        #8;
        MR = 1'b0;

        // Vector table for u_a (MODULUS=10, WRAP=1)
        for (int k = 1; k <= 10; k++)
            tbl.push_back(mk(0, 0, 1, 1, 1, 4'd0, k % 10, k == 10, k == 9));
        tbl.push_back(mk(0, 1, 1, 1, 1, 4'd14, 9, 0, 1));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(0, 0, 1, 1, 0, 4'd0, 9 - k, 0, k == 9));
        tbl.push_back(mk(0, 0, 1, 1, 0, 4'd0, 9, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'd0, 9, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'd0, 9, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 4'd0, 9, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 4'd3, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 4'd9, 9, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 1, 4'd7, 7, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 4'd0, 8, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 4'd0, 9, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 4'd0, 0, 1, 0));

        foreach (tbl[i]) begin
            a_sr  = tbl[i].sr;
            a_ld  = tbl[i].ld;
            a_cep = tbl[i].cep;
            a_cet = tbl[i].cet;
            a_dir = tbl[i].dir;
            a_d   = tbl[i].d;
            edge1();
            chk($sformatf("tbl%0d_q", i), a_q, tbl[i].q);
            chk($sformatf("tbl%0d_ovf", i), a_ovf, tbl[i].ovf);
            chk($sformatf("tbl%0d_tc", i), a_tc, tbl[i].tc);
            chk($sformatf("tbl%0d_done", i), a_done, 0);
        end
        a_sr = 0;
        a_ld = 0;

        // TC follows Cet and Dir without a clock edge
        a_cep = 0;
        a_cet = 1;
        a_dir = 0;
        #1;
        chk("tc_comb_down_q0", a_tc, 1);
        a_cet = 0;
        #1;
        chk("tc_comb_cet_low", a_tc, 0);

        // Saturation on u_s (MODULUS=6, WRAP=0)
        s_cep = 1;
        for (int k = 1; k <= 5; k++) begin
            edge1();
            chk("sat_q", s_q, k);
            chk("sat_done_early", s_done, 0);
            chk("sat_tc", s_tc, k == 5);
        end
        repeat (2) begin
            edge1();
            chk("sat_hold_q", s_q, 5);
            chk("sat_done", s_done, 1);
            chk("sat_ovf", s_ovf, 0);
        end
        s_dir = 0;
        edge1();
        chk("sat_resume_q", s_q, 4);
        chk("sat_resume_done", s_done, 1);
        s_sr = 1;
        edge1();
        chk("sat_sr_q", s_q, 0);
        chk("sat_sr_done", s_done, 0);
        s_sr = 0;
        s_cep = 0;

        // Two-stage decimal cascade
        c_cep = 1;
        for (int k = 1; k <= 100; k++) begin
            edge1();
            chk("casc_count", int'(c1_q) * 10 + int'(c0_q), k % 100);
            chk("casc_ovf1", c1_ovf, k == 100);
        end
        c_cep = 0;

        // MR asserted mid-count
        a_cep = 1;
        a_cet = 1;
        a_dir = 1;
        repeat (3) edge1();
        chk("mr_pre_q", a_q, 3);
        #3;
        MR = 1'b1;
        #1;
        chk("mr_async_q", a_q, 0);
        chk("mr_async_ovf", a_ovf, 0);
        @(posedge Clk);
        #2;
        MR = 1'b0;
        edge1();
        chk("mr_restart_q", a_q, 1);

        // Randomized run against the reference model
        MR = 1'b1;
        #1;
        MR = 1'b0;
        ma = '{0, 1'b0, 1'b0};
        mb = '{0, 1'b0, 1'b0};
        ms = '{0, 1'b0, 1'b0};
        for (int i = 0; i < 400; i++) begin
            a_sr  = ($urandom_range(15) == 0);
            a_ld  = ($urandom_range(7) == 0);
            a_cep = ($urandom_range(3) != 0);
            a_cet = ($urandom_range(3) != 0);
            a_dir = 1'($urandom_range(1));
            a_d   = 4'($urandom_range(15));
            s_sr  = ($urandom_range(15) == 0);
            s_ld  = ($urandom_range(11) == 0);
            s_cep = ($urandom_range(3) != 0);
            s_cet = ($urandom_range(3) != 0);
            s_dir = ($urandom_range(3) != 0);
            s_d   = 4'($urandom_range(15));
            #1;
            chk("rnd_a_tc", a_tc, mtc(ma.q, a_cet, a_dir, 10));
            chk("rnd_b_tc", b_tc, mtc(mb.q, a_cet, a_dir, 2));
            chk("rnd_s_tc", s_tc, mtc(ms.q, s_cet, s_dir, 6));
            edge1();
            ma = mstep(ma, a_sr, a_ld, a_cep, a_cet, a_dir, int'(a_d), 10, 1'b1);
            mb = mstep(mb, a_sr, a_ld, a_cep, a_cet, a_dir, int'(a_d[2:0]), 2, 1'b1);
            ms = mstep(ms, s_sr, s_ld, s_cep, s_cet, s_dir, int'(s_d), 6, 1'b0);
            chk("rnd_a_q", a_q, ma.q);
            chk("rnd_a_ovf", a_ovf, ma.ovf);
            chk("rnd_a_done", a_done, ma.done);
            chk("rnd_b_q", b_q, mb.q);
            chk("rnd_b_ovf", b_ovf, mb.ovf);
            chk("rnd_s_q", s_q, ms.q);
            chk("rnd_s_ovf", s_ovf, ms.ovf);
            chk("rnd_s_done", s_done, ms.done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
